sseg7_p2s_driver: RTL and testbench
===================================

Name: sseg7_p2s_driver

Overview:
Downstream consumer of the 8-channel display multiplexer. It takes the selected 32-bit display word plus the 8-bit point and blink masks, and converts each hex nibble to an active-low 7-segment byte. It applies decimal points and the blink phase, then shifts the resulting 64 bits serially to the board's cascaded shift-register chain and strobes a latch. The block runs one frame per start request and holds a handshake (busy/done) for the refresh sequencer.

Parameters:
SCLK_HALF, 2, clk cycles per half-period of seg_clk (>=1)
BLINK_BITS, 25, width of free-running blink counter; blink phase = counter[BLINK_BITS-1]

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset; asynchronous and active-high; clears all state
start  input  1  frame request; sampled only in IDLE
disp_num  input  32  eight hex digits; digit i = disp_num[4i+3:4i]
point_in  input  8  bit i=1 lights decimal point of digit i
blink_in  input  8  bit i=1 makes digit i blink
seg_clk  output  1  serial shift clock to display chain
seg_sout  output  1  serial data, valid before and during seg_clk rising edge
seg_latch  output  1  storage-register latch strobe after the final bit
busy  output  1  high from LOAD through LATCH
done  output  1  one-cycle pulse when frame complete

Behaviour:
- Reset values: seg_clk=0, seg_sout=0, seg_latch=0, busy=0, done=0, state=IDLE, bit counter=0, blink counter=0.
- Reset asserted mid-frame aborts immediately; no partial latch pulse is issued.
- Blink counter: BLINK_BITS wide, increments every clk, wraps to 0, and is never cleared by start.
- Segment byte order is {dp,g,f,e,d,c,b,a}, active-low (0 = lit).
- Hex codes with dp off: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E.
- point_in[i]=1 clears bit 7 of the byte for digit i.
- If blink_in[i]=1 and the blink phase is 1, the byte for digit i is forced to FF (blank). Blanking overrides the point.
- IDLE: all outputs 0. If start=1, go to LOAD on the next edge.
- start is ignored in every other state, including DONE.
- LOAD (1 cycle): the inputs and blink phase present in this cycle build the 64-bit frame, digit 7 byte first, MSB first. busy=1.
- SHIFT (64 bits): for each bit, seg_sout holds the bit. seg_clk=0 for SCLK_HALF cycles, then seg_clk=1 for SCLK_HALF cycles.
- seg_sout changes only while seg_clk is low, at the start of each bit's low phase.
- LATCH: seg_clk=0, seg_latch=1 for SCLK_HALF cycles. seg_sout stays at the last bit.
- DONE (1 cycle): done=1, busy=0. Then return to IDLE. A start raised in DONE is dropped; it must be held or re-raised in IDLE.
- Latency: if start is sampled in cycle 0, LOAD is cycle 1 and done is high in cycle 129*SCLK_HALF+2 (260 for the default SCLK_HALF=2). busy is high in cycles 1..129*SCLK_HALF+1.
- Exactly 64 rising edges of seg_clk per frame; no edge occurs during LATCH or IDLE.
- Input changes after LOAD do not affect the frame in flight.

Test Plan:
1. SCLK_HALF=2, disp_num=32'h01234567, point_in=0, blink_in=0, start pulse in cycle 0 -> bytes captured on seg_clk rising edges are C0,F9,A4,B0,99,92,82,F8. Exactly 64 edges; seg_latch high 2 cycles; done high in cycle 260 only.
2. disp_num=32'hFFFFFFFF, point_in=8'h81 -> bytes 0E,8E,8E,8E,8E,8E,8E,0E.
3. BLINK_BITS=4, blink_in=8'h0F, disp_num=32'h88888888, start timed so LOAD falls at blink counter=8 -> bytes 80,80,80,80,FF,FF,FF,FF. Repeat with LOAD at counter=0 -> all eight bytes 80.
4. start held high continuously -> frames back-to-back: each new LOAD occurs 2 cycles after the prior done (DONE, then IDLE samples start). No start is accepted while busy=1.
5. rst asserted asynchronously after the 20th seg_clk rising edge -> all outputs 0 within the same cycle, no seg_latch pulse, no done. After rst release and start, a full correct 64-bit frame follows.
6. SCLK_HALF=1, disp_num=32'hDEADBEEF -> done in cycle 131; bytes A1,86,88,A1,83,86,86,8E.

Source files
------------

// File: rtl/sseg7_p2s_driver.sv
// Serial driver for an 8-digit cascaded 7-segment display: hex decode, point/blink
// overlay, 64-bit MSB-first shift with a generated shift clock, then a latch strobe.
module sseg7_p2s_driver #(
   parameter int SCLK_HALF  = 2,
   parameter int BLINK_BITS = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] disp_num,
   input  logic [7:0]  point_in,
   input  logic [7:0]  blink_in,
   output logic        seg_clk,
   output logic        seg_sout,
   output logic        seg_latch,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DONE} state_t;

   localparam int PW = $clog2(2 * SCLK_HALF);
   localparam logic [PW-1:0] PH_RISE = PW'(SCLK_HALF - 1);
   localparam logic [PW-1:0] PH_END  = PW'(2 * SCLK_HALF - 1);

   state_t                state;
   logic [63:0]           sreg;
   logic [5:0]            bit_cnt;
   logic [PW-1:0]         ph_cnt;
   logic [BLINK_BITS-1:0] blink_cnt;
   logic [63:0]           frame;
   logic [7:0]            seg_byte;

   // Active-low segments in {dp,g,f,e,d,c,b,a} order, decimal point off.
   function automatic logic [7:0] hex_to_seg(input logic [3:0] d);
      case (d)
         4'h0:    return 8'hC0;
         4'h1:    return 8'hF9;
         4'h2:    return 8'hA4;
         4'h3:    return 8'hB0;
         4'h4:    return 8'h99;
         4'h5:    return 8'h92;
         4'h6:    return 8'h82;
         4'h7:    return 8'hF8;
         4'h8:    return 8'h80;
         4'h9:    return 8'h90;
         4'hA:    return 8'h88;
         4'hB:    return 8'h83;
         4'hC:    return 8'hC6;
         4'hD:    return 8'hA1;
         4'hE:    return 8'h86;
         default: return 8'h8E;
      endcase
   endfunction

   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      frame    = '0;
      seg_byte = '0;
      for (int i = 0; i < 8; i++) begin
         seg_byte = hex_to_seg(disp_num[4*i +: 4]);
         if (point_in[i])
            seg_byte[7] = 1'b0;
         if (blink_in[i] && blink_cnt[BLINK_BITS-1])
            seg_byte = 8'hFF;
         frame[8*i +: 8] = seg_byte;
      end
   end

   // Free-running so the blink rate is independent of how often frames are requested.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         blink_cnt <= '0;
      else
         blink_cnt <= blink_cnt + BLINK_BITS'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      if (rst) begin
         state     <= IDLE;
         sreg      <= '0;
         bit_cnt   <= '0;
         ph_cnt    <= '0;
         seg_clk   <= 1'b0;
         seg_sout  <= 1'b0;
         seg_latch <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               seg_clk   <= 1'b0;
               seg_sout  <= 1'b0;
               seg_latch <= 1'b0;
               busy      <= 1'b0;
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               // First bit goes straight to the pin; sreg keeps the remaining 63.
               seg_sout <= frame[63];
               sreg     <= {frame[62:0], 1'b0};
               seg_clk  <= 1'b0;
               ph_cnt   <= '0;
               bit_cnt  <= '0;
               state    <= SHIFT;
            end
            SHIFT: begin
               if (ph_cnt == PH_END) begin
                  ph_cnt  <= '0;
                  seg_clk <= 1'b0;
                  if (bit_cnt == 6'd63) begin
                     seg_latch <= 1'b1;
                     state     <= LATCH;
                  end else begin
                     bit_cnt  <= bit_cnt + 6'd1;
                     seg_sout <= sreg[63];
                     sreg     <= {sreg[62:0], 1'b0};
                  end
               end else begin
                  ph_cnt <= ph_cnt + PW'(1);
                  if (ph_cnt == PH_RISE)
                     seg_clk <= 1'b1;
               end
            end
            LATCH: begin
               if (ph_cnt == PH_RISE) begin
                  seg_latch <= 1'b0;
                  seg_sout  <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  ph_cnt <= ph_cnt + PW'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sseg7_p2s_driver.sv
// Directed bench for sseg7_p2s_driver: one instance at SCLK_HALF=2 (short blink
// counter) and one at SCLK_HALF=1, with frames reassembled from seg_clk edges.
module tb_sseg7_p2s_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_start, b_start;
   logic [31:0] disp_num;
   logic [7:0]  point_in, blink_in;
   logic        a_seg_clk, a_seg_sout, a_seg_latch, a_busy, a_done;
   logic        b_seg_clk, b_seg_sout, b_seg_latch, b_busy, b_done;

   int n_checks = 0;
   int n_pass   = 0;

   sseg7_p2s_driver #(.SCLK_HALF(2), .BLINK_BITS(4)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .disp_num(disp_num),
      .point_in(point_in), .blink_in(blink_in), .seg_clk(a_seg_clk),
      .seg_sout(a_seg_sout), .seg_latch(a_seg_latch), .busy(a_busy), .done(a_done)
   );

   sseg7_p2s_driver #(.SCLK_HALF(1), .BLINK_BITS(25)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .disp_num(disp_num),
      .point_in(point_in), .blink_in(blink_in), .seg_clk(b_seg_clk),
      .seg_sout(b_seg_sout), .seg_latch(b_seg_latch), .busy(b_busy), .done(b_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bench copy of the 4-bit blink counter, used to time LOAD against the blink phase.
   logic [3:0] bm;
   always @(posedge clk or posedge rst) begin
      if (rst) bm <= 4'd0;
      else     bm <= bm + 4'd1;
   end

   logic [63:0] cap_a = '0, cap_b = '0;
   int edg_a = 0, edg_b = 0;
   always @(posedge a_seg_clk) begin
      cap_a <= {cap_a[62:0], a_seg_sout};
      edg_a <= edg_a + 1;
   end
   always @(posedge b_seg_clk) begin
      cap_b <= {cap_b[62:0], b_seg_sout};
      edg_b <= edg_b + 1;
   end

   int lat_a = 0, done_a = 0, dcyc_a = 0, lcyc_a = 0;
   int lat_b = 0, done_b = 0, dcyc_b = 0, lcyc_b = 0;
   logic pb_a = 1'b0, pb_b = 1'b0;
   always @(negedge clk) begin
      if (a_seg_latch) lat_a <= lat_a + 1;
      if (a_done) begin
         done_a <= done_a + 1;
         dcyc_a <= cyc;
      end
      if (a_busy && !pb_a) lcyc_a <= cyc;
      pb_a <= a_busy;
   end
   always @(negedge clk) begin
      if (b_seg_latch) lat_b <= lat_b + 1;
      if (b_done) begin
         done_b <= done_b + 1;
         dcyc_b <= cyc;
      end
      if (b_busy && !pb_b) lcyc_b <= cyc;
      pb_b <= b_busy;
   end

   function automatic int g_edges(input int w); return (w != 0) ? edg_b : edg_a; endfunction
   function automatic int g_lat(input int w);   return (w != 0) ? lat_b : lat_a; endfunction
   function automatic int g_done(input int w);  return (w != 0) ? done_b : done_a; endfunction
   function automatic int g_dcyc(input int w);  return (w != 0) ? dcyc_b : dcyc_a; endfunction
   function automatic int g_lcyc(input int w);  return (w != 0) ? lcyc_b : lcyc_a; endfunction
   function automatic logic [63:0] g_cap(input int w); return (w != 0) ? cap_b : cap_a; endfunction
   function automatic logic g_busy(input int w); return (w != 0) ? b_busy : a_busy; endfunction
   function automatic logic [4:0] g_outs(input int w);
      return (w != 0) ? {b_seg_clk, b_seg_sout, b_seg_latch, b_busy, b_done}
                      : {a_seg_clk, a_seg_sout, a_seg_latch, a_busy, a_done};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic wait_done(input int w, input int target, input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk); #1;
         if (g_done(w) >= target) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, " done seen"}, 64'(seen), 64'd1);
   endtask

   // Call at a negedge: start is pulsed for exactly one sampling edge.
   task automatic run_frame(input int w, input string tag, input logic [31:0] num,
                            input logic [7:0] pt, input logic [7:0] bl,
                            input logic [63:0] exp_frame, input int exp_done, input int half);
      int e0, l0, d0, base;
      #1;
      e0 = g_edges(w);
      l0 = g_lat(w);
      d0 = g_done(w);
      disp_num = num;
      point_in = pt;
      blink_in = bl;
      if (w != 0) b_start = 1'b1;
      else        a_start = 1'b1;
      @(negedge clk); #1;
      a_start = 1'b0;
      b_start = 1'b0;
      base = cyc;
      check({tag, " busy in load"}, 64'(g_busy(w)), 64'd1);
      check({tag, " load cycle"}, 64'(g_lcyc(w)), 64'(base));
      wait_done(w, d0 + 1, tag);
      check({tag, " done cycle"}, 64'(g_dcyc(w) - base + 1), 64'(exp_done));
      @(negedge clk);
      @(negedge clk); #1;
      check({tag, " frame"}, g_cap(w), exp_frame);
      check({tag, " edges"}, 64'(g_edges(w) - e0), 64'd64);
      check({tag, " latch cycles"}, 64'(g_lat(w) - l0), 64'(half));
      check({tag, " done pulses"}, 64'(g_done(w) - d0), 64'd1);
      check({tag, " idle outputs"}, 64'(g_outs(w)), 64'd0);
   endtask

   initial begin
      int e0, l0, d0, d1;
      bit hit;
      rst = 1'b1;
      a_start = 1'b0;
      b_start = 1'b0;
      disp_num = '0;
      point_in = '0;
      blink_in = '0;
      #2;
      check("reset outputs a", 64'(g_outs(0)), 64'd0);
      check("reset outputs b", 64'(g_outs(1)), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_frame(0, "t1 01234567", 32'h01234567, 8'h00, 8'h00,
                64'hC0F9A4B0_999282F8, 260, 2);
      run_frame(0, "t2 points", 32'hFFFFFFFF, 8'h81, 8'h00,
                64'h0E8E8E8E_8E8E8E0E, 260, 2);

      hit = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bm == 4'd7) begin hit = 1'b1; break; end
      end
      check("t3 align phase1", 64'(hit), 64'd1);
      run_frame(0, "t3 blink on", 32'h88888888, 8'h00, 8'h0F,
                64'h80808080_FFFFFFFF, 260, 2);
      hit = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bm == 4'd15) begin hit = 1'b1; break; end
      end
      check("t3 align phase0", 64'(hit), 64'd1);
      run_frame(0, "t3 blink off", 32'h88888888, 8'h00, 8'h0F,
                64'h80808080_80808080, 260, 2);

      // Held start: two frames back to back, next LOAD two cycles after each done.
      @(negedge clk); #1;
      e0 = edg_a;
      d0 = done_a;
      disp_num = 32'h01234567;
      point_in = 8'h00;
      blink_in = 8'h00;
      a_start = 1'b1;
      wait_done(0, d0 + 1, "t4 first");
      d1 = dcyc_a;
      wait_done(0, d0 + 2, "t4 second");
      a_start = 1'b0;
      check("t4 reload gap", 64'(lcyc_a - d1), 64'd2);
      check("t4 done spacing", 64'(dcyc_a - d1), 64'd261);
      check("t4 edges", 64'(edg_a - e0), 64'd128);
      check("t4 frame", cap_a, 64'hC0F9A4B0_999282F8);
      repeat (3) @(negedge clk);
      #1;
      check("t4 stopped", 64'(a_busy), 64'd0);

      // Async reset mid-frame.
      @(negedge clk); #1;
      e0 = edg_a;
      l0 = lat_a;
      d0 = done_a;
      a_start = 1'b1;
      @(negedge clk); #1;
      a_start = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         if (edg_a - e0 >= 20) begin hit = 1'b1; break; end
      end
      check("t5 reached edge 20", 64'(hit), 64'd1);
      rst = 1'b1;
      #1;
      check("t5 outputs in reset", 64'(g_outs(0)), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("t5 edges before abort", 64'(edg_a - e0), 64'd20);
      check("t5 no latch", 64'(lat_a - l0), 64'd0);
      check("t5 no done", 64'(done_a - d0), 64'd0);
      check("t5 idle after reset", 64'(g_outs(0)), 64'd0);
      @(negedge clk);
      run_frame(0, "t5 after reset", 32'h89ABCDEF, 8'h10, 8'h00,
                64'h80908803_C6A1868E, 260, 2);

      @(negedge clk);
      run_frame(1, "t6 half1", 32'hDEADBEEF, 8'h00, 8'h00,
                64'hA18688A1_8386868E, 131, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
